// File: rtl/floppy_track_loader.sv
// Track loader: streams whole NIB tracks between the SD image and the drive track RAM,
// writing a modified track back before the next track is read and stalling the CPU meanwhile.
`timescale 1ns/1ps

module floppy_track_loader #(
    parameter int unsigned SECTORS_PER_TRACK = 13,
    parameter int unsigned TRACK_BITS        = 6
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [TRACK_BITS-1:0] track,
    input  logic                  track_dirty,
    input  logic                  img_mounted,
    input  logic                  img_readonly,
    input  logic [63:0]           img_size,
    output logic [31:0]           sd_lba,
    output logic                  sd_rd,
    output logic                  sd_wr,
    input  logic                  sd_ack,
    output logic [3:0]            track_sec,
    output logic                  cpu_wait,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StWb, StRd, StAbort} state_e;

    state_e                  state_q, state_d;
    logic [TRACK_BITS-1:0]   cur_track_q, cur_track_d;
    logic                    dirty_q, dirty_d;
    logic                    reload_q, reload_d;
    logic [31:0]             sd_lba_q, sd_lba_d;
    logic                    sd_rd_q, sd_rd_d;
    logic                    sd_wr_q, sd_wr_d;
    logic [3:0]              track_sec_q, track_sec_d;
    logic                    cpu_wait_q, cpu_wait_d;
    logic                    old_ack_q;

    logic ack_rise, ack_fall, last_sec, start_rd;

    function automatic logic [31:0] track_lba(input logic [TRACK_BITS-1:0] t);
        return 32'(SECTORS_PER_TRACK) * 32'(t);
    endfunction

    assign ack_rise = ~old_ack_q & sd_ack;
    assign ack_fall = old_ack_q & ~sd_ack;
    assign last_sec = (track_sec_q == 4'(SECTORS_PER_TRACK - 1));

    always_comb begin
        state_d     = state_q;
        cur_track_d = cur_track_q;
        dirty_d     = dirty_q;
        reload_d    = reload_q;
        sd_lba_d    = sd_lba_q;
        sd_rd_d     = sd_rd_q;
        sd_wr_d     = sd_wr_q;
        track_sec_d = track_sec_q;
        cpu_wait_d  = cpu_wait_q;
        start_rd    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A mount pulse only arms the reload; it starts once the pulse is gone.
                if (!img_mounted) begin
                    if (img_size == 64'd0) begin
                        cur_track_d = track;
                        reload_d    = 1'b0;
                    end else if (dirty_q && !img_readonly && (track != cur_track_q)) begin
                        state_d     = StWb;
                        sd_lba_d    = track_lba(cur_track_q);
                        track_sec_d = 4'd0;
                        sd_wr_d     = 1'b1;
                        cpu_wait_d  = 1'b1;
                        dirty_d     = 1'b0;
                    end else if ((track != cur_track_q) || reload_q) begin
                        start_rd = 1'b1;
                        if (track != cur_track_q) dirty_d = 1'b0;
                    end
                end
            end
            StWb, StRd: begin
                if (img_mounted) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    if (sd_ack) begin
                        state_d = StAbort;
                    end else begin
                        state_d    = StIdle;
                        cpu_wait_d = 1'b0;
                    end
                end else if (ack_rise && last_sec) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                end else if (ack_fall) begin
                    if (sd_rd_q || sd_wr_q) begin
                        track_sec_d = track_sec_q + 4'd1;
                        sd_lba_d    = sd_lba_q + 32'd1;
                    end else if (state_q == StWb) begin
                        start_rd = 1'b1;
                    end else begin
                        state_d    = StIdle;
                        cpu_wait_d = 1'b0;
                    end
                end
            end
            StAbort: begin
                // hps_io must finish the sector it is acking before anything new starts.
                if (ack_fall) begin
                    if (!img_mounted && (img_size != 64'd0)) begin
                        start_rd = 1'b1;
                    end else begin
                        state_d    = StIdle;
                        cpu_wait_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_rd) begin
            state_d     = StRd;
            cur_track_d = track;
            reload_d    = 1'b0;
            sd_lba_d    = track_lba(track);
            track_sec_d = 4'd0;
            sd_rd_d     = 1'b1;
            sd_wr_d     = 1'b0;
            cpu_wait_d  = 1'b1;
        end

        if (track_dirty) dirty_d = 1'b1;
        // A new image invalidates whatever the drive wrote to the old one.
        if (img_mounted) begin
            dirty_d  = 1'b0;
            reload_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_track_q <= '0;
            dirty_q     <= 1'b0;
            reload_q    <= 1'b1;
            sd_lba_q    <= 32'd0;
            sd_rd_q     <= 1'b0;
            sd_wr_q     <= 1'b0;
            track_sec_q <= 4'd0;
            cpu_wait_q  <= 1'b0;
            old_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_track_q <= cur_track_d;
            dirty_q     <= dirty_d;
            reload_q    <= reload_d;
            sd_lba_q    <= sd_lba_d;
            sd_rd_q     <= sd_rd_d;
            sd_wr_q     <= sd_wr_d;
            track_sec_q <= track_sec_d;
            cpu_wait_q  <= cpu_wait_d;
            old_ack_q   <= sd_ack;
        end
    end

    assign sd_lba    = sd_lba_q;
    assign sd_rd     = sd_rd_q;
    assign sd_wr     = sd_wr_q;
    assign track_sec = track_sec_q;
    assign cpu_wait  = cpu_wait_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_floppy_track_loader.sv
// Directed bench for floppy_track_loader: an hps_io-like responder acks every sector and logs
// the LBA, sector index and direction, which each scenario compares with hand-computed values.
`timescale 1ns/1ps

module tb_floppy_track_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [5:0]  track;
    logic        track_dirty, img_mounted, img_readonly;
    logic [63:0] img_size;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [3:0]  track_sec;
    logic        cpu_wait, busy;

    floppy_track_loader #(
        .SECTORS_PER_TRACK(13),
        .TRACK_BITS       (6)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .track       (track),
        .track_dirty (track_dirty),
        .img_mounted (img_mounted),
        .img_readonly(img_readonly),
        .img_size    (img_size),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .track_sec   (track_sec),
        .cpu_wait    (cpu_wait),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int fails  = 0;

    logic [31:0] lba_q[$];
    logic [3:0]  sec_q[$];
    bit          wr_q[$];
    bit          resp_en = 1'b0;

    int stable_err = 0;
    int both_err   = 0;
    int wait_err   = 0;
    int wait_rises = 0;
    int cyc        = 0;
    int last_ack_fall  = -100;
    int last_wait_fall = -200;
    logic prev_wait = 1'b0;
    logic prev_ack  = 1'b0;

    // Sector responder: 4-cycle ack per request, re-arming right after each fall.
    initial begin
        sd_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (resp_en && (sd_rd || sd_wr)) begin
                lba_q.push_back(sd_lba);
                sec_q.push_back(track_sec);
                wr_q.push_back(sd_wr);
                sd_ack = 1'b1;
                repeat (4) begin
                    @(posedge clk_sys);
                    #1;
                    if (sd_lba !== lba_q[$] || track_sec !== sec_q[$]) stable_err++;
                end
                sd_ack = 1'b0;
            end
        end
    end

    always @(negedge clk_sys) begin
        cyc <= cyc + 1;
        if (sd_rd && sd_wr) both_err <= both_err + 1;
        if (cpu_wait !== busy) wait_err <= wait_err + 1;
        if (cpu_wait && !prev_wait) wait_rises <= wait_rises + 1;
        if (!cpu_wait && prev_wait) last_wait_fall <= cyc;
        if (!sd_ack && prev_ack) last_ack_fall <= cyc;
        prev_wait <= cpu_wait;
        prev_ack  <= sd_ack;
    end

    task automatic clear_log();
        lba_q.delete();
        sec_q.delete();
        wr_q.delete();
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        repeat (3) @(posedge clk_sys);
        while (busy && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (6) @(posedge clk_sys);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_timeout busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; track = 6'd0; track_dirty = 1'b0; img_mounted = 1'b0;
        img_readonly = 1'b0; img_size = 64'd232960; resp_en = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        checks++;
        if (sd_lba !== 32'd0) begin
            fails++; $display("FAIL reset_lba got %0d required 0", sd_lba);
        end
        checks++;
        if ({sd_rd, sd_wr} !== 2'b00) begin
            fails++; $display("FAIL reset_req got %b required 00", {sd_rd, sd_wr});
        end
        checks++;
        if (track_sec !== 4'd0) begin
            fails++; $display("FAIL reset_sec got %0d required 0", track_sec);
        end
        checks++;
        if ({cpu_wait, busy} !== 2'b00) begin
            fails++; $display("FAIL reset_wait_busy got %b required 00", {cpu_wait, busy});
        end
        @(posedge clk_sys);
        #1 reset = 1'b0;
        wait_done("reset_load");
        checks++;
        if (lba_q.size() != 13) begin
            fails++; $display("FAIL reset_load_count got %0d required 13", lba_q.size());
        end
        for (int i = 0; i < lba_q.size() && i < 13; i++) begin
            checks++;
            if ({wr_q[i], lba_q[i], sec_q[i]} !== {1'b0, 32'(i), 4'(i)}) begin
                fails++;
                $display("FAIL reset_load_sector%0d got wr=%b lba=%0d sec=%0d required wr=0 lba=%0d sec=%0d",
                         i, wr_q[i], lba_q[i], sec_q[i], i, i);
            end
        end
        checks++;
        if (last_wait_fall - last_ack_fall != 1) begin
            fails++;
            $display("FAIL reset_wait_release got %0d cycles after last fall required 1",
                     last_wait_fall - last_ack_fall);
        end
        checks++;
        if (wait_rises != 1) begin
            fails++; $display("FAIL reset_wait_rises got %0d required 1", wait_rises);
        end
    endtask

    task automatic test_track_change();
        clear_log();
        @(posedge clk_sys);
        #1 track = 6'd5;
        wait_done("track5");
        checks++;
        if (lba_q.size() != 13) begin
            fails++; $display("FAIL track5_count got %0d required 13", lba_q.size());
        end
        for (int i = 0; i < lba_q.size() && i < 13; i++) begin
            checks++;
            if ({wr_q[i], lba_q[i], sec_q[i]} !== {1'b0, 32'(65 + i), 4'(i)}) begin
                fails++;
                $display("FAIL track5_sector%0d got wr=%b lba=%0d sec=%0d required wr=0 lba=%0d sec=%0d",
                         i, wr_q[i], lba_q[i], sec_q[i], 65 + i, i);
            end
        end
    endtask

    task automatic test_dirty_writeback();
        int r0 = wait_rises;
        clear_log();
        @(posedge clk_sys);
        #1 track_dirty = 1'b1;
        @(posedge clk_sys);
        #1 track_dirty = 1'b0;
        track = 6'd6;
        wait_done("writeback");
        checks++;
        if (lba_q.size() != 26) begin
            fails++; $display("FAIL writeback_count got %0d required 26", lba_q.size());
        end
        for (int i = 0; i < lba_q.size() && i < 26; i++) begin
            logic        ew = (i < 13);
            logic [31:0] el = 32'(65 + i);
            logic [3:0]  es = (i < 13) ? 4'(i) : 4'(i - 13);
            checks++;
            if ({wr_q[i], lba_q[i], sec_q[i]} !== {ew, el, es}) begin
                fails++;
                $display("FAIL writeback_sector%0d got wr=%b lba=%0d sec=%0d required wr=%b lba=%0d sec=%0d",
                         i, wr_q[i], lba_q[i], sec_q[i], ew, el, es);
            end
        end
        checks++;
        if (wait_rises - r0 != 1) begin
            fails++; $display("FAIL writeback_wait_gap got %0d rises required 1", wait_rises - r0);
        end
    endtask

    task automatic test_readonly();
        img_readonly = 1'b1;
        @(posedge clk_sys);
        #1 track = 6'd5;
        wait_done("ro_back");
        clear_log();
        @(posedge clk_sys);
        #1 track_dirty = 1'b1;
        @(posedge clk_sys);
        #1 track_dirty = 1'b0;
        track = 6'd6;
        wait_done("ro_load");
        checks++;
        if (lba_q.size() != 13) begin
            fails++; $display("FAIL ro_count got %0d required 13", lba_q.size());
        end
        for (int i = 0; i < lba_q.size() && i < 13; i++) begin
            checks++;
            if ({wr_q[i], lba_q[i], sec_q[i]} !== {1'b0, 32'(78 + i), 4'(i)}) begin
                fails++;
                $display("FAIL ro_sector%0d got wr=%b lba=%0d sec=%0d required wr=0 lba=%0d sec=%0d",
                         i, wr_q[i], lba_q[i], sec_q[i], 78 + i, i);
            end
        end
        // The discarded dirty flag must not cause a write once protection is lifted.
        img_readonly = 1'b0;
        clear_log();
        @(posedge clk_sys);
        #1 track = 6'd7;
        wait_done("ro_discard");
        checks++;
        if (lba_q.size() != 13 || wr_q[0] !== 1'b0 || lba_q[0] !== 32'd91) begin
            fails++;
            $display("FAIL ro_discard got count=%0d first_lba=%0d required count=13 first_lba=91",
                     lba_q.size(), (lba_q.size() > 0) ? lba_q[0] : 32'hffffffff);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        clear_log();
        @(posedge clk_sys);
        #1 track = 6'd2;
        @(posedge clk_sys);
        #1 track_dirty = 1'b1;
        @(posedge clk_sys);
        #1 track_dirty = 1'b0;
        while (!(lba_q.size() == 5 && sd_ack) && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        checks++;
        if (!(lba_q.size() == 5 && sd_ack)) begin
            fails++; $display("FAIL abort_reach_sector4 got count=%0d required 5", lba_q.size());
        end
        img_mounted = 1'b1;
        @(posedge clk_sys);
        #1 img_mounted = 1'b0;
        checks++;
        if ({sd_rd, sd_wr, sd_ack, busy} !== 4'b0011) begin
            fails++;
            $display("FAIL abort_drop got rd=%b wr=%b ack=%b busy=%b required 0 0 1 1",
                     sd_rd, sd_wr, sd_ack, busy);
        end
        wait_done("abort");
        checks++;
        if (lba_q.size() != 18) begin
            fails++; $display("FAIL abort_count got %0d required 18", lba_q.size());
        end
        for (int i = 0; i < lba_q.size() && i < 18; i++) begin
            int k = (i < 5) ? i : i - 5;
            checks++;
            if ({wr_q[i], lba_q[i], sec_q[i]} !== {1'b0, 32'(26 + k), 4'(k)}) begin
                fails++;
                $display("FAIL abort_sector%0d got wr=%b lba=%0d sec=%0d required wr=0 lba=%0d sec=%0d",
                         i, wr_q[i], lba_q[i], sec_q[i], 26 + k, k);
            end
        end
        clear_log();
        @(posedge clk_sys);
        #1 track = 6'd3;
        wait_done("abort_clean");
        checks++;
        if (lba_q.size() != 13 || wr_q[0] !== 1'b0 || lba_q[0] !== 32'd39) begin
            fails++;
            $display("FAIL abort_dirty_cleared got count=%0d first_wr=%b required count=13 first_wr=0",
                     lba_q.size(), (wr_q.size() > 0) ? wr_q[0] : 1'b1);
        end
    endtask

    task automatic test_no_image();
        int r0 = wait_rises;
        img_size = 64'd0;
        clear_log();
        @(posedge clk_sys);
        #1 track = 6'd0;
        repeat (5) @(posedge clk_sys);
        #1 track = 6'd3;
        repeat (20) @(posedge clk_sys);
        #1;
        checks++;
        if (lba_q.size() != 0) begin
            fails++; $display("FAIL noimg_requests got %0d required 0", lba_q.size());
        end
        checks++;
        if (wait_rises != r0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL noimg_wait got rises=%0d busy=%b required 0 0", wait_rises - r0, busy);
        end
        img_size = 64'd232960;
        img_mounted = 1'b1;
        @(posedge clk_sys);
        #1 img_mounted = 1'b0;
        wait_done("mount_load");
        checks++;
        if (lba_q.size() != 13) begin
            fails++; $display("FAIL mount_count got %0d required 13", lba_q.size());
        end
        for (int i = 0; i < lba_q.size() && i < 13; i++) begin
            checks++;
            if ({wr_q[i], lba_q[i], sec_q[i]} !== {1'b0, 32'(39 + i), 4'(i)}) begin
                fails++;
                $display("FAIL mount_sector%0d got wr=%b lba=%0d sec=%0d required wr=0 lba=%0d sec=%0d",
                         i, wr_q[i], lba_q[i], sec_q[i], 39 + i, i);
            end
        end
    endtask

    task automatic test_invariants();
        @(negedge clk_sys);
        checks++;
        if (stable_err != 0) begin
            fails++; $display("FAIL lba_stable_during_ack got %0d changes required 0", stable_err);
        end
        checks++;
        if (both_err != 0) begin
            fails++; $display("FAIL rd_wr_exclusive got %0d cycles required 0", both_err);
        end
        checks++;
        if (wait_err != 0) begin
            fails++; $display("FAIL wait_tracks_busy got %0d cycles required 0", wait_err);
        end
    endtask

    initial begin
        test_reset();
        test_track_change();
        test_dirty_writeback();
        test_readonly();
        test_abort();
        test_no_image();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
